// File: rtl/rng_harvest_if.sv
// Read-side bundle of rng_harvest: show-ahead valid/ready port plus FIFO status.
// master = harvester (drives data and status), slave = downstream consumer.
interface rng_harvest_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                         rd_ready_i;
  logic                         rd_valid_o;
  logic [WIDTH-1:0]             rd_data_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;
  logic                         full_o;

  modport master (
    input  rd_ready_i,
    output rd_valid_o,
    output rd_data_o,
    output count_o,
    output full_o
  );

  modport slave (
    output rd_ready_i,
    input  rd_valid_o,
    input  rd_data_o,
    input  count_o,
    input  full_o
  );
endinterface

// File: rtl/rng_harvest.sv
// Decimating sampler for the LHCA generator state word with repetition-count health
// test and a small show-ahead FIFO. Optional whitening: define RNG_HARVEST_WHITEN_EN.
//
// state  | meaning
// IDLE   | harvesting disabled, FIFO still readable
// WARMUP | captures feed the health test only, then discarded
// RUN    | captures feed the health test and are pushed
// FAIL   | repetition test tripped; waits for clear_fail_i
module rng_harvest #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 4,
  parameter int SAMPLE_DIV     = 4,
  parameter int WARMUP_SAMPLES = 16,
  parameter int REP_LIMIT      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] rng_i,
  input  logic             clear_fail_i,
  output logic             health_fail_o,
  rng_harvest_if.master    rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WW = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [WW-1:0] WARM_LOAD = WW'(WARMUP_SAMPLES - 1);
  localparam logic [RW-1:0] REP_TRIP  = RW'(REP_LIMIT);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, FAIL} state_t;

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [WW-1:0]    warm_cnt;
  logic [RW-1:0]    run_cnt;
  logic [WIDTH-1:0] last_cap;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             capture;
  logic             trip;
  logic             push;
  logic             pop;
  logic             full;
  logic [RW-1:0]    run_next;
  logic [WIDTH-1:0] store_word;

  // A capture in the same cycle en_i drops is suppressed: leaving for IDLE wins.
  always_comb begin
    capture  = 1'b0;
    run_next = RW'(1);
    trip     = 1'b0;
    if ((state == WARMUP || state == RUN) && en_i && div_cnt == DIV_LAST) begin
      capture = 1'b1;
    end
    if (rng_i == last_cap) begin
      run_next = run_cnt + RW'(1);
    end
    if (capture && run_next == REP_TRIP) begin
      trip = 1'b1;
    end
  end

`ifdef RNG_HARVEST_WHITEN_EN
  assign store_word = rng_i ^ last_cap;
`else
  assign store_word = rng_i;
`endif

  assign full = (count == CNT_FULL);
  assign push = capture && (state == RUN) && !trip && !full;
  assign pop  = (count != '0) && rd.rd_ready_i && !trip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      warm_cnt      <= '0;
      run_cnt       <= '0;
      last_cap      <= '0;
      health_fail_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en_i) begin
            state    <= WARMUP;
            div_cnt  <= '0;
            warm_cnt <= WARM_LOAD;
            run_cnt  <= '0;
          end
        end
        WARMUP, RUN: begin
          if (!en_i) begin
            state <= IDLE;
          end else begin
            div_cnt <= capture ? '0 : div_cnt + DW'(1);
            if (capture) begin
              if (trip) begin
                state         <= FAIL;
                health_fail_o <= 1'b1;
                last_cap      <= '0;
                run_cnt       <= '0;
              end else begin
                last_cap <= rng_i;
                run_cnt  <= run_next;
                if (state == WARMUP) begin
                  if (warm_cnt == '0) state <= RUN;
                  else                warm_cnt <= warm_cnt - WW'(1);
                end
              end
            end
          end
        end
        default: begin
          if (clear_fail_i) begin
            health_fail_o <= 1'b0;
            if (en_i) begin
              state    <= WARMUP;
              div_cnt  <= '0;
              warm_cnt <= WARM_LOAD;
              run_cnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // A trip flushes the FIFO on the same edge, overriding any pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (trip) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= store_word;
  end

  assign rd.rd_valid_o = (count != '0);
  assign rd.rd_data_o  = (count != '0) ? mem[rd_ptr] : '0;
  assign rd.count_o    = count;
  assign rd.full_o     = full;

endmodule

// File: tb/tb_rng_harvest.sv
// Directed + randomized bench for rng_harvest against a queue-based behavioural model.
module tb_rng_harvest;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int SDIV  = 4;
  localparam int WARM  = 2;
  localparam int REP   = 3;

  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_RUN  = 2;
  localparam int M_FAIL = 3;

`ifdef RNG_HARVEST_WHITEN_EN
  localparam bit WHITEN = 1'b1;
`else
  localparam bit WHITEN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        en    = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] rng   = '0;
  logic        health_fail;

  rng_harvest_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

  rng_harvest #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SAMPLE_DIV(SDIV),
    .WARMUP_SAMPLES(WARM), .REP_LIMIT(REP)
  ) u_dut (
    .clk(clk), .rst(rst), .en_i(en), .rng_i(rng),
    .clear_fail_i(clear), .health_fail_o(health_fail), .rd(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit use_cnt = 1'b0;

  int          m_mode;
  int          m_since;
  int          m_caps;
  logic [31:0] m_last;
  logic [31:0] m_win[$];
  logic [31:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      $error("%s miscompared", tag);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_since = 0; m_caps = 0; m_last = '0;
    m_win.delete(); m_q.delete();
  endtask

  task automatic enter_warm();
    m_mode = M_WARM; m_since = 0; m_caps = 0; m_win.delete();
  endtask

  function automatic bit cap_next();
    return (m_mode == M_WARM || m_mode == M_RUN) && en && ((m_since % SDIV) == SDIV - 1);
  endfunction

  // Advance the model across one clock edge using the inputs as they stand now.
  task automatic model_step();
    int sz0;
    bit do_pop, do_push, flush, cap, trip;
    logic [31:0] word;
    sz0 = m_q.size();
    do_pop = (sz0 > 0) && bus.rd_ready_i;
    do_push = 1'b0; flush = 1'b0; word = '0;
    case (m_mode)
      M_IDLE: if (en) enter_warm();
      M_WARM, M_RUN: begin
        if (!en) m_mode = M_IDLE;
        else begin
          cap = (m_since % SDIV) == SDIV - 1;
          m_since++;
          if (cap) begin
            m_win.push_back(rng);
            if (m_win.size() > REP) void'(m_win.pop_front());
            trip = (m_win.size() == REP);
            for (int k = 1; k < m_win.size(); k++) if (m_win[k] != m_win[0]) trip = 1'b0;
            if (trip) begin
              flush = 1'b1; m_mode = M_FAIL; m_win.delete(); m_last = '0;
            end else begin
              word = WHITEN ? (rng ^ m_last) : rng;
              do_push = (m_mode == M_RUN) && (sz0 < DEPTH);
              m_last = rng;
              if (m_mode == M_WARM) begin
                m_caps++;
                if (m_caps == WARM) m_mode = M_RUN;
              end
            end
          end
        end
      end
      default: if (clear) begin
        if (en) enter_warm();
        else    m_mode = M_IDLE;
      end
    endcase
    if (flush) m_q.delete();
    else begin
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back(word);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 32'h0;
    chk("rd_valid", 32'(bus.rd_valid_o), 32'(m_q.size() > 0));
    chk("rd_data", bus.rd_data_o, head);
    chk("count", 32'(bus.count_o), 32'(m_q.size()));
    chk("full", 32'(bus.full_o), 32'(m_q.size() == DEPTH));
    chk("health_fail", 32'(health_fail), 32'(m_mode == M_FAIL));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    cyc++;
    if (use_cnt) rng = 32'(cyc);
  endtask

  initial begin
    bus.rd_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // warm-up and capture with a counting source
    use_cnt = 1'b1; en = 1'b1; rng = 32'(cyc);
    repeat (20) tick();
    bus.rd_ready_i = 1'b1;
    repeat (12) tick();
    use_cnt = 1'b0;

    // stuck source trips the repetition test
    bus.rd_ready_i = 1'b0; rng = 32'hDEADBEEF;
    for (int i = 0; i < 40 && m_mode != M_FAIL; i++) tick();
    chk("stuck_fail", 32'(health_fail), 32'h1);
    repeat (6) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_drops_fail", 32'(health_fail), 32'h0);
    repeat (14) tick();
    clear = 1'b1; rng = $urandom; tick(); clear = 1'b0;

    // backpressure: fill, drop, single pop, refill
    for (int i = 0; i < 40; i++) begin rng = $urandom; tick(); end
    chk("saturated_full", 32'(bus.full_o), 32'h1);
    for (int i = 0; i < 8 && cap_next(); i++) begin rng = $urandom; tick(); end
    bus.rd_ready_i = 1'b1; rng = $urandom; tick(); bus.rd_ready_i = 1'b0;
    chk("after_one_pop", 32'(bus.count_o), 32'd3);
    repeat (5) begin rng = $urandom; tick(); end

    // simultaneous push and pop at count 2
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
        if (m_q.size() == 2 && cap_next() && m_mode == M_RUN) begin
          bus.rd_ready_i = 1'b1; hit = 1'b1;
        end else if (m_q.size() > 2 && !cap_next()) bus.rd_ready_i = 1'b1;
        else bus.rd_ready_i = 1'b0;
        rng = $urandom; tick();
      end
      chk("simul_count", 32'(bus.count_o), 32'd2);
      bus.rd_ready_i = 1'b1;
      repeat (16) begin rng = $urandom; tick(); end
    end

    // randomized traffic with a small alphabet to provoke health failures
    for (int i = 0; i < 500; i++) begin
      bus.rd_ready_i = 1'($urandom_range(0, 1));
      rng = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if ($urandom_range(0, 59) == 0) en = ~en;
      clear = ($urandom_range(0, 7) == 0);
      tick();
    end
    clear = 1'b0;

    // mid-run asynchronous reset with three words buffered
    en = 1'b1; clear = 1'b1; rng = $urandom; tick(); clear = 1'b0;
    bus.rd_ready_i = 1'b0;
    for (int i = 0; i < 100 && !(m_mode == M_RUN && m_q.size() == 3); i++) begin
      rng = $urandom; tick();
    end
    chk("pre_rst_count", 32'(bus.count_o), 32'd3);
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.rd_valid_o), 32'h0);
    chk("rst_data", bus.rd_data_o, 32'h0);
    chk("rst_count", 32'(bus.count_o), 32'h0);
    chk("rst_full", 32'(bus.full_o), 32'h0);
    chk("rst_fail", 32'(health_fail), 32'h0);
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    rst = 1'b1;
    repeat (30) begin rng = $urandom; tick(); end

    // whitening pair 0x000000FF then 0x00000F0F
    bus.rd_ready_i = 1'b1;
    repeat (24) begin rng = $urandom; tick(); end
    for (int i = 0; i < 40 && !(cap_next() && m_mode == M_RUN); i++) begin rng = $urandom; tick(); end
    rng = 32'h0000_00FF; tick();
    rng = 32'h0000_0F0F;
    for (int i = 0; i < 8 && !cap_next(); i++) tick();
    tick();
    chk("whiten_word", bus.rd_data_o, WHITEN ? 32'h0000_0FF0 : 32'h0000_0F0F);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rng_harvest.md
# rng_harvest

Consumer-side companion to the LHCA random-number generator. It decimates and samples the generator's parallel state word and runs a repetition-count health test on every sample. Accepted samples are buffered in a small FIFO and served to downstream crypto logic over a valid/ready handshake. It sits between `rng_top`'s `out_random_num` and any key or nonce consumer.

## Interface
Parameters:
- `WIDTH`, 32: width of `rng_i` and `rd_data_o`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SAMPLE_DIV`, 4: cycles between captures; ≥1.
- `WARMUP_SAMPLES`, 16: captures discarded after start or recovery; ≥1.
- `REP_LIMIT`, 4: number of consecutive identical raw captures that declares failure; ≥2.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  harvesting enable.
- `rng_i`  in  WIDTH  generator state word, sampled synchronously.
- `rd_ready_i`  in  1  consumer ready.
- `rd_valid_o`  out  1  FIFO non-empty.
- `rd_data_o`  out  WIDTH  FIFO head word; 0 when empty.
- `count_o`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `full_o`  out  1  count_o == DEPTH.
- `health_fail_o`  out  1  high while in FAIL.
- `clear_fail_i`  in  1  leave FAIL.

## Operation
- States:
  - IDLE: no capture.
  - WARMUP: capture and discard; the health test still runs.
  - RUN: capture and push.
  - FAIL: no capture.
- Transitions:
  - IDLE→WARMUP when `en_i`=1.
  - WARMUP→RUN after WARMUP_SAMPLES captures.
  - Any state except FAIL →IDLE when `en_i`=0.
  - WARMUP/RUN→FAIL when the repetition test trips.
  - FAIL→WARMUP on `clear_fail_i`=1 with `en_i`=1; FAIL→IDLE on `clear_fail_i`=1 with `en_i`=0.
  - `clear_fail_i` is ignored outside FAIL.
- Decimation counter:
  - Cleared to 0 on entry to WARMUP.
  - Increments each cycle in WARMUP/RUN.
  - A capture occurs in a cycle where the counter equals SAMPLE_DIV-1; the counter wraps to 0 in that cycle.
- Repetition test:
  - A register holds the last raw capture.
  - A run counter is reset to 1 on a differing capture and incremented on an equal capture.
  - When the run counter reaches REP_LIMIT: enter FAIL, flush the FIFO (count_o=0), and clear the last-capture register and run counter.
  - The run counter is cleared on entry to WARMUP.
- Push: a RUN capture pushes only if `full_o`=0 at that edge. A capture while full is dropped, but it still updates the health test.
- Pop: occurs when `rd_valid_o` && `rd_ready_i`. `rd_data_o` is show-ahead, so the head word is valid in the same cycle.
- Simultaneous push and pop: count_o is unchanged and both pointers advance. Push while full is never allowed, even when a pop happens in the same cycle.
- Pointers: log2(DEPTH) bits, natural wrap.
- When `en_i` drops, FIFO contents are retained and remain readable from IDLE.

## Timing
- Reset values:
  - State IDLE; all counters and pointers 0.
  - `rd_valid_o`=0, `rd_data_o`=0, `count_o`=0, `full_o`=0, `health_fail_o`=0.
- Asserting `rst` mid-operation forces all reset values immediately. It is asynchronous and independent of `clk`.
- Pushed word appears on `rd_data_o` and `rd_valid_o` rises one cycle after the capture edge.
- `health_fail_o` rises the cycle after the tripping capture edge. The flush takes effect on that same edge.
- `full_o` and `count_o` are registered and update on the push/pop edge.
- The first RUN capture happens SAMPLE_DIV cycles after the previous warm-up capture.

## Configuration
- Macro: `RNG_HARVEST_WHITEN_EN`.
- Defined:
  - The stored word is the current raw capture XOR the previous raw capture.
  - The previous-capture register is the one used by the health test.
  - The first RUN capture after WARMUP uses the last warm-up capture as its partner.
- Undefined: the raw capture is stored unmodified.
- The health test always operates on raw captures.

## Test plan
Unless stated otherwise, parameters are WIDTH=32, DEPTH=4, SAMPLE_DIV=4, WARMUP_SAMPLES=2, REP_LIMIT=3; whitening undefined.

1. **Warm-up and capture.** Release `rst`; `en_i`=1; `rng_i` = free-running cycle counter. Required:
   - The first two captures are discarded.
   - The first stored word equals the `rng_i` value at the third capture edge.
   - `rd_valid_o` rises one cycle later.
   - Subsequent stored words differ by 4.
2. **Stuck source.** `rng_i` held at 32'hDEADBEEF. Required:
   - `health_fail_o`=1 the cycle after the third capture, with `count_o`=0.
   - No pushes occur while in FAIL.
   - A one-cycle `clear_fail_i` pulse drops `health_fail_o` and re-enters WARMUP.
3. **Backpressure.** `rd_ready_i`=0 with a changing `rng_i`. Required:
   - `count_o` saturates at 4 with `full_o`=1, and later captures are dropped.
   - After one pop, `count_o`=3, and the next capture is stored behind the retained words in order.
4. **Simultaneous push and pop.** Pop on a capture edge with `count_o`=2. Required: `count_o` stays 2 and FIFO order is preserved.
5. **Mid-run reset.** Assert `rst` between edges with `count_o`=3 in RUN. Required: all outputs reach reset values immediately, and operation restarts at IDLE.
6. **Whitening.** Define `RNG_HARVEST_WHITEN_EN`; raw captures 32'h0000_00FF then 32'h0000_0F0F. Required: the stored word is 32'h0000_0FF0.
